// File: rtl/weight_loader.sv
// weight_loader: writable 16-entry weight store filled from a valid/ready byte stream, with a combinational ROM-style read port.
// Optional feature macro WLOAD_CHECKSUM_EN: requires a trailing modulo-2^WIDTH sum byte after the weights and reports a mismatch on err.
module weight_loader #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [3:0]       addr,
    output logic [WIDTH-1:0] out_weight,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [4:0]       load_count
);
    // Handshake: a byte transfers on a rising edge with in_valid && in_ready; in_ready is
    // combinational in start (never high in a start cycle); in_data holds while in_valid waits.
`ifdef WLOAD_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

    localparam logic [4:0] LAST = 5'(DEPTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] w [DEPTH];
    logic [3:0]       ptr;
    logic             accept;

`ifdef WLOAD_CHECKSUM_EN
    assign busy = (state == LOAD) || (state == CHECK);
`else
    assign busy = (state == LOAD);
`endif
    assign in_ready   = busy && !start;
    assign accept     = in_valid && in_ready;
    assign out_weight = w[addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            LOAD: begin
                if (accept && load_count == LAST) begin
`ifdef WLOAD_CHECKSUM_EN
                    state_nxt = CHECK;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef WLOAD_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
        // A start pulse restarts the load from entry 0 regardless of the current state.
        if (start) begin
            state_nxt = LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                w[i] <= '0;
            end
            ptr        <= '0;
            load_count <= '0;
        end else if (start) begin
            ptr        <= '0;
            load_count <= '0;
        end else if (accept && state == LOAD) begin
            w[ptr]     <= in_data;
            ptr        <= ptr + 4'd1;
            load_count <= load_count + 5'd1;
        end
    end

`ifdef WLOAD_CHECKSUM_EN
    logic [WIDTH-1:0] sum;
    logic             err_q;

    // The running sum covers only the current load; the byte after the last weight is the checksum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else if (start) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            if (state == LOAD) begin
                sum <= sum + in_data;
            end else begin
                err_q <= (in_data != sum);
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
